// File: rtl/alu_secuencial.sv
// Multi-cycle N-bit ALU: single-pass ops finish in one cycle, multiply/divide/modulo
// iterate N times over a shared {hi, lo} shift register. Outputs are registered and held.
module alu_secuencial #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic [3:0]   ALU_Sel,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] ALU_Out,
    output logic         FlagZ,
    output logic         FlagN,
    output logic         FlagV,
    output logic         FlagC
);
    localparam int CW = $clog2(N) + 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_MUL = 4'b0010;
    localparam logic [3:0] OP_DIV = 4'b0011;
    localparam logic [3:0] OP_MOD = 4'b0100;
    localparam logic [3:0] OP_AND = 4'b0101;
    localparam logic [3:0] OP_OR  = 4'b0110;
    localparam logic [3:0] OP_XOR = 4'b0111;
    localparam logic [3:0] OP_SHL = 4'b1000;
    localparam logic [3:0] OP_SHR = 4'b1001;

    // Handshake: start is only sampled in IDLE; done is a one-cycle pulse in DONE, and busy
    // covers every non-IDLE cycle, so a new start is taken in the first IDLE cycle after done.
    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N-1:0]  hi_q, hi_d, lo_q, lo_d, b_q, b_d;
    logic [3:0]    op_q, op_d;
    logic [N-1:0]  out_q, out_d;
    logic          z_q, z_d, n_q, n_d, v_q, v_d, c_q, c_d;

    logic [N-1:0]  sp_res;
    logic          sp_v, sp_c, b_big, is_iter;
    logic [N:0]    add_full, sub_full, shl_full, shr_full;

    always_comb begin
        add_full = {1'b0, A} + {1'b0, B};
        sub_full = {1'b0, A} - {1'b0, B};
        shl_full = {1'b0, A} << B;
        shr_full = {A, 1'b0} >> B;
        b_big    = (32'(B) >= 32'(N));
        is_iter  = ((ALU_Sel == OP_MUL) || (ALU_Sel == OP_DIV) || (ALU_Sel == OP_MOD)) && (B != '0);
        sp_res   = '0;
        sp_v     = 1'b0;
        sp_c     = 1'b0;
        case (ALU_Sel)
            OP_ADD: begin
                sp_res = add_full[N-1:0];
                sp_c   = add_full[N];
                sp_v   = (A[N-1] == B[N-1]) && (add_full[N-1] != A[N-1]);
            end
            OP_SUB: begin
                sp_res = sub_full[N-1:0];
                sp_c   = sub_full[N];
                sp_v   = (A[N-1] != B[N-1]) && (sub_full[N-1] != A[N-1]);
            end
            OP_MUL: sp_res = '0;  // only reached with B == 0
            OP_DIV: begin
                sp_res = '1;
                sp_v   = 1'b1;
            end
            OP_MOD: begin
                sp_res = A;
                sp_v   = 1'b1;
            end
            OP_AND: sp_res = A & B;
            OP_OR:  sp_res = A | B;
            OP_XOR: sp_res = A ^ B;
            OP_SHL: if (!b_big) {sp_c, sp_res} = shl_full;
            OP_SHR: if (!b_big) {sp_res, sp_c} = shr_full;
            default: sp_res = N'(1);
        endcase
    end

    // One iteration of shift-add multiply (hi accumulates, lo holds the multiplier) and of
    // restoring division (hi is the partial remainder, lo shifts dividend out / quotient in).
    logic [N:0]   mul_sum, rem_sh, rem_diff;
    logic         rem_ge;
    logic [N-1:0] step_hi, step_lo;

    always_comb begin
        mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
        rem_sh   = {hi_q, lo_q[N-1]};
        rem_ge   = (rem_sh >= {1'b0, b_q});
        rem_diff = rem_sh - {1'b0, b_q};
        if (op_q == OP_MUL) begin
            step_hi = mul_sum[N:1];
            step_lo = {mul_sum[0], lo_q[N-1:1]};
        end else begin
            step_hi = rem_ge ? rem_diff[N-1:0] : rem_sh[N-1:0];
            step_lo = {lo_q[N-2:0], rem_ge};
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        b_d     = b_q;
        op_d    = op_q;
        out_d   = out_q;
        z_d     = z_q;
        n_d     = n_q;
        v_d     = v_q;
        c_d     = c_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d = ALU_Sel;
                    b_d  = B;
                    if (is_iter) begin
                        state_d = S_CALC;
                        cnt_d   = CW'(N - 1);
                        hi_d    = '0;
                        lo_d    = A;
                    end else begin
                        state_d = S_DONE;
                        out_d   = sp_res;
                        v_d     = sp_v;
                        c_d     = sp_c;
                        z_d     = (sp_res == '0);
                        n_d     = sp_res[N-1];
                    end
                end
            end
            S_CALC: begin
                hi_d  = step_hi;
                lo_d  = step_lo;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    state_d = S_DONE;
                    cnt_d   = '0;
                    out_d   = (op_q == OP_MOD) ? step_hi : step_lo;
                    v_d     = (op_q == OP_MUL) && (step_hi != '0);
                    c_d     = 1'b0;
                    z_d     = (out_d == '0);
                    n_d     = out_d[N-1];
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            b_q     <= '0;
            op_q    <= '0;
            out_q   <= '0;
            z_q     <= 1'b0;
            n_q     <= 1'b0;
            v_q     <= 1'b0;
            c_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            b_q     <= b_d;
            op_q    <= op_d;
            out_q   <= out_d;
            z_q     <= z_d;
            n_q     <= n_d;
            v_q     <= v_d;
            c_q     <= c_d;
        end
    end

    assign busy    = (state_q != S_IDLE);
    assign done    = (state_q == S_DONE);
    assign ALU_Out = out_q;
    assign FlagZ   = z_q;
    assign FlagN   = n_q;
    assign FlagV   = v_q;
    assign FlagC   = c_q;
endmodule

// File: tb/tb_alu_secuencial.sv
// Bench for alu_secuencial (N=8): driver issues ops and queues model results; a monitor
// pops and compares result, flags and done latency on every done pulse.
module tb_alu_secuencial;
    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst, start;
    logic [N-1:0] a, b;
    logic [3:0]   sel;
    logic         busy, done;
    logic [N-1:0] alu_out;
    logic         flag_z, flag_n, flag_v, flag_c;

    alu_secuencial #(.N(N)) dut (
        .clk(clk), .rst(rst), .start(start), .A(a), .B(b), .ALU_Sel(sel),
        .busy(busy), .done(done), .ALU_Out(alu_out),
        .FlagZ(flag_z), .FlagN(flag_n), .FlagV(flag_v), .FlagC(flag_c)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_pass = 0;
    int n_total = 0;
    logic [11:0] exp_q[$];
    int          due_q[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    endtask

    // Reference model: {V, C, N, Z, result}, computed with plain integer arithmetic.
    function automatic logic [11:0] model(input logic [7:0] ta, input logic [7:0] tb_, input logic [3:0] ts);
        int ia, ib, sa, sb, r;
        bit v, c;
        logic [7:0] res;
        ia = ta; ib = tb_;
        sa = $signed(ta); sb = $signed(tb_);
        r = 0; v = 0; c = 0;
        case (ts)
            4'd0: begin r = ia + ib; c = (r > 255); v = (sa + sb > 127) || (sa + sb < -128); end
            4'd1: begin r = ia - ib; c = (ia < ib); v = (sa - sb > 127) || (sa - sb < -128); end
            4'd2: begin r = ia * ib; v = (r > 255); end
            4'd3: if (ib == 0) begin r = 255; v = 1; end else r = ia / ib;
            4'd4: if (ib == 0) begin r = ia; v = 1; end else r = ia % ib;
            4'd5: r = ia & ib;
            4'd6: r = ia | ib;
            4'd7: r = ia ^ ib;
            4'd8: begin
                r = (ib >= 8) ? 0 : (ia << ib);
                c = (ib >= 1 && ib <= 7) ? (((ia >> (8 - ib)) & 1) != 0) : 0;
            end
            4'd9: begin
                r = (ib >= 8) ? 0 : (ia >> ib);
                c = (ib >= 1 && ib <= 7) ? (((ia >> (ib - 1)) & 1) != 0) : 0;
            end
            default: r = 1;
        endcase
        res = r[7:0];
        return {v, c, res[7], (res == 8'd0), res};
    endfunction

    function automatic int latency(input logic [7:0] tb_, input logic [3:0] ts);
        return ((ts == 4'd2 || ts == 4'd3 || ts == 4'd4) && tb_ != 8'd0) ? N + 1 : 1;
    endfunction

    // Monitor
    always @(negedge clk) begin
        if (!rst && done) begin
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_done: got done=1 expected no done (cycle %0d)", cyc);
            end else begin
                check("result_flags", {flag_v, flag_c, flag_n, flag_z, alu_out}, exp_q.pop_front());
                check("done_latency", cyc, due_q.pop_front());
                check("busy_with_done", busy, 1'b1);
            end
        end
    end

    // Driver: glitch pulses start while busy and again during the DONE cycle.
    task automatic do_op(input logic [7:0] ta, input logic [7:0] tb_, input logic [3:0] ts, input bit glitch);
        bit seen;
        @(negedge clk);
        a = ta; b = tb_; sel = ts; start = 1'b1;
        exp_q.push_back(model(ta, tb_, ts));
        due_q.push_back(cyc + latency(tb_, ts));
        @(negedge clk);
        start = 1'b0;
        a = 8'($urandom); b = 8'($urandom); sel = 4'($urandom);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            start = (glitch && i == 2) ? 1'b1 : 1'b0;
            @(negedge clk);
        end
        start = glitch;
        check("done_seen", seen, 1'b1);
        @(negedge clk);
        start = 1'b0;
        check("busy_after_done", busy, 1'b0);
        check("done_one_cycle", done, 1'b0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        logic [7:0] ra, rb;
        rst = 1'b1; start = 1'b0; a = '0; b = '0; sel = '0;
        repeat (3) @(negedge clk);
        check("reset_busy", busy, 1'b0);
        check("reset_done", done, 1'b0);
        check("reset_out_flags", {flag_v, flag_c, flag_n, flag_z, alu_out}, 12'h000);
        rst = 1'b0;

        do_op(8'h7F, 8'h01, 4'd0, 1'b0);
        do_op(8'h03, 8'h05, 4'd1, 1'b0);
        do_op(8'd15, 8'd17, 4'd2, 1'b0);
        do_op(8'd16, 8'd16, 4'd2, 1'b1);
        do_op(8'd200, 8'd7, 4'd3, 1'b0);
        do_op(8'd200, 8'd7, 4'd4, 1'b1);
        do_op(8'd5, 8'd0, 4'd3, 1'b0);
        do_op(8'd5, 8'd0, 4'd4, 1'b0);
        do_op(8'h81, 8'd1, 4'd8, 1'b0);
        do_op(8'h81, 8'd1, 4'd9, 1'b0);
        do_op(8'h81, 8'd8, 4'd8, 1'b0);
        do_op(8'h81, 8'd7, 4'd8, 1'b0);
        do_op(8'h81, 8'd7, 4'd9, 1'b0);
        do_op(8'h81, 8'd0, 4'd9, 1'b0);
        do_op(8'h80, 8'h80, 4'd0, 1'b0);
        do_op(8'h80, 8'h01, 4'd1, 1'b0);
        do_op(8'hFF, 8'hFF, 4'd2, 1'b0);
        do_op(8'hFF, 8'h01, 4'd3, 1'b0);
        do_op(8'h12, 8'h34, 4'd13, 1'b0);

        for (int i = 0; i < 150; i++) begin
            ra = 8'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 9)) : 8'($urandom);
            do_op(ra, rb, 4'($urandom_range(0, 15)), ($urandom_range(0, 4) == 0));
        end

        do_op(8'hA5, 8'h0F, 4'd6, 1'b0);
        // Abort a multiply during its fourth cycle; no done pulse may follow.
        @(negedge clk);
        a = 8'd16; b = 8'd16; sel = 4'd2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("busy_mid_mul", busy, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", busy, 1'b0);
        check("abort_done", done, 1'b0);
        check("abort_out_flags", {flag_v, flag_c, flag_n, flag_z, alu_out}, 12'h000);
        repeat (12) @(negedge clk);
        check("abort_still_idle", busy, 1'b0);

        do_op(8'd9, 8'd3, 4'd3, 1'b0);
        repeat (3) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
